// File: rtl/mem_access_ctrl_if.sv
// Bundle between the pipeline's memory stage, the load/store controller and the RAM bus.
// The controller owns the master modport; the pipeline/RAM side uses slave.
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
);
  logic                  mem_read_flag_in;
  logic                  mem_write_flag_in;
  logic                  mem_sign_ext_flag_in;
  logic [SEL_WIDTH-1:0]  mem_sel_in;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [31:0]           result_in;
  logic                  flush;
  // RAM handshake: once ram_en rises, ram_en/ram_addr/ram_write_en/ram_write_data stay
  // stable until a rising edge samples ram_ready high; ram_read_data is valid with ram_ready.
  logic                  ram_en;
  logic [SEL_WIDTH-1:0]  ram_write_en;
  logic [31:0]           ram_addr;
  logic [DATA_WIDTH-1:0] ram_write_data;
  logic [DATA_WIDTH-1:0] ram_read_data;
  logic                  ram_ready;
  logic                  stall_request;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_valid;
  logic                  addr_error;
  logic                  bus_error;
  logic [1:0]            fsm_state;

  modport master (
    input  mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in, mem_sel_in,
           mem_write_data, result_in, flush, ram_read_data, ram_ready,
    output ram_en, ram_write_en, ram_addr, ram_write_data, stall_request,
           load_data, load_valid, addr_error, bus_error, fsm_state
  );

  modport slave (
    output mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in, mem_sel_in,
           mem_write_data, result_in, flush, ram_read_data, ram_ready,
    input  ram_en, ram_write_en, ram_addr, ram_write_data, stall_request,
           load_data, load_valid, addr_error, bus_error, fsm_state
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store unit: aligns and issues one RAM bus cycle per access, stalls the pipeline
// while waiting, and returns an aligned, size-extended load result.
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 255
) (
  input logic clk,
  input logic rst,
  mem_access_ctrl_if.master bus
);
  localparam int LB = $clog2(SEL_WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t                state;
  logic [15:0]           count;
  logic [LB-1:0]         lane_q;
  logic [3:0]            size_q;
  logic                  sign_q;
  logic                  store_q;
  logic                  ram_en_q;
  logic [SEL_WIDTH-1:0]  ram_write_en_q;
  logic [31:0]           ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_write_data_q;
  logic [DATA_WIDTH-1:0] load_data_q;
  logic                  load_valid_q;
  logic                  addr_error_q;
  logic                  bus_error_q;

  logic [LB-1:0]         lane;
  logic [LB-1:0]         lane_mask;
  logic [3:0]            size;
  logic                  sel_legal;
  logic                  start;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] size_mask;
  logic                  sign_bit;
  logic [DATA_WIDTH-1:0] extended;

  always_comb begin
    lane      = bus.result_in[LB-1:0];
    sel_legal = 1'b0;
    size      = 4'd1;
    lane_mask = '0;
    if (bus.mem_sel_in == SEL_WIDTH'(4'h1)) begin
      sel_legal = 1'b1;
      size      = 4'd1;
      lane_mask = LB'(0);
    end else if (bus.mem_sel_in == SEL_WIDTH'(4'h3)) begin
      sel_legal = 1'b1;
      size      = 4'd2;
      lane_mask = LB'(1);
    end else if (bus.mem_sel_in == SEL_WIDTH'(4'hF)) begin
      sel_legal = 1'b1;
      size      = 4'd4;
      lane_mask = LB'(3);
    end else if (SEL_WIDTH == 8 && bus.mem_sel_in == SEL_WIDTH'(8'hFF)) begin
      sel_legal = 1'b1;
      size      = 4'd8;
      lane_mask = LB'(7);
    end
    misaligned = !sel_legal || ((lane & lane_mask) != '0);
    start      = (state == IDLE) && (bus.mem_read_flag_in || bus.mem_write_flag_in) && !bus.flush;
  end

  // Load extraction uses the lane/size/sign captured at start, not the live inputs.
  always_comb begin
    shifted   = bus.ram_read_data >> {lane_q, 3'b000};
    size_mask = ~({DATA_WIDTH{1'b1}} << {size_q, 3'b000});
    sign_bit  = sign_q && |(shifted & (size_mask ^ (size_mask >> 1)));
    extended  = sign_bit ? (shifted | ~size_mask) : (shifted & size_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      count            <= '0;
      lane_q           <= '0;
      size_q           <= 4'd1;
      sign_q           <= 1'b0;
      store_q          <= 1'b0;
      ram_en_q         <= 1'b0;
      ram_write_en_q   <= '0;
      ram_addr_q       <= '0;
      ram_write_data_q <= '0;
      load_data_q      <= '0;
      load_valid_q     <= 1'b0;
      addr_error_q     <= 1'b0;
      bus_error_q      <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      addr_error_q <= 1'b0;
      bus_error_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && misaligned) begin
            addr_error_q <= 1'b1;
          end else if (start) begin
            state            <= REQ;
            count            <= '0;
            lane_q           <= lane;
            size_q           <= size;
            sign_q           <= bus.mem_sign_ext_flag_in;
            store_q          <= bus.mem_write_flag_in;
            ram_en_q         <= 1'b1;
            ram_addr_q       <= {bus.result_in[31:LB], {LB{1'b0}}};
            ram_write_data_q <= bus.mem_write_data << {lane, 3'b000};
            ram_write_en_q   <= bus.mem_write_flag_in ? (bus.mem_sel_in << lane) : '0;
          end
        end
        REQ: begin
          if (bus.ram_ready) begin
            state          <= DONE;
            ram_en_q       <= 1'b0;
            ram_write_en_q <= '0;
            if (!store_q) begin
              load_data_q  <= extended;
              load_valid_q <= 1'b1;
            end
          end else if (count == 16'(TIMEOUT - 1)) begin
            state            <= DONE;
            ram_en_q         <= 1'b0;
            ram_write_en_q   <= '0;
            ram_addr_q       <= '0;
            ram_write_data_q <= '0;
            bus_error_q      <= 1'b1;
          end else begin
            count <= count + 16'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall_request  = (state == REQ) || (start && !misaligned);
  assign bus.ram_en         = ram_en_q;
  assign bus.ram_write_en   = ram_write_en_q;
  assign bus.ram_addr       = ram_addr_q;
  assign bus.ram_write_data = ram_write_data_q;
  assign bus.load_data      = load_data_q;
  assign bus.load_valid     = load_valid_q;
  assign bus.addr_error     = addr_error_q;
  assign bus.bus_error      = bus_error_q;
  assign bus.fsm_state      = state;
endmodule
